// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS32 control path.
// Build option BNE_EN: adds bne (000101) as a legal branch opcode.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctrl_word_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control-unit to datapath bundle: opcode/zero in, control word out.
// master = control unit, slave = datapath side.
interface main_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               zero;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic [1:0]         pc_src;
  logic               pc_en;
  logic               illegal_op;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  opcode, zero,
    output iord, mem_write, ir_write, reg_dst,
    output mem_to_reg, reg_write, alu_src_a,
    output alu_src_b, alu_op, pc_src, pc_en,
    output illegal_op, dbg_state
  );

  modport slave (
    output opcode, zero,
    input  iord, mem_write, ir_write, reg_dst,
    input  mem_to_reg, reg_write, alu_src_a,
    input  alu_src_b, alu_op, pc_src, pc_en,
    input  illegal_op, dbg_state
  );
endinterface

// File: rtl/ctrl_output_decode.sv
// Moore decode of the FSM state into the datapath control word.
// Only BRANCH looks at zero (xor is_bne for the bne variant).
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       zero_i,
  input  logic       is_bne_i,
  output ctrl_word_t cw_o
);

  // Per-state control word; unlisted fields stay 0.
  always_comb begin
    cw_o = '0;
    unique case (state_i)
      S_FETCH: begin
        cw_o.ir_write  = 1'b1;
        cw_o.alu_src_b = SRCB_FOUR;
        cw_o.alu_op    = ALU_OP_ADD;
        cw_o.pc_src    = PCSRC_ALU;
        cw_o.pc_en     = 1'b1;
      end
      S_DECODE: begin
        cw_o.alu_src_b = SRCB_IMM_SH;
        cw_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMRD: begin
        cw_o.iord = 1'b1;
      end
      S_MEMWB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw_o.iord      = 1'b1;
        cw_o.mem_write = 1'b1;
      end
      S_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_B;
        cw_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        cw_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_B;
        cw_o.alu_op    = ALU_OP_SUB;
        cw_o.pc_src    = PCSRC_ALUOUT;
        cw_o.pc_en     = zero_i ^ is_bne_i;
      end
      S_JUMP: begin
        cw_o.pc_src = PCSRC_JUMP;
        cw_o.pc_en  = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS32 main control FSM (FETCH/DECODE/execute sequencing).
// Build option BNE_EN: decode bne into BRANCH with inverted condition.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  main_control_fsm_if.master bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       is_bne;
  ctrl_word_t cw;

`ifdef BNE_EN
  logic is_bne_q, is_bne_d;

  // Remember at DECODE whether the branch is a bne.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_bne_q <= 1'b0;
    end else begin
      is_bne_q <= is_bne_d;
    end
  end

  // Capture only in DECODE; hold otherwise.
  always_comb begin
    is_bne_d = is_bne_q;
    if (state_q == S_DECODE) begin
      is_bne_d = (bus.opcode == OP_BNE);
    end
  end

  assign is_bne = is_bne_q;
`else
  assign is_bne = 1'b0;
`endif

  // State and illegal-opcode pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; opcode only matters in DECODE/MEMADR.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.opcode == OP_LW),
          (bus.opcode == OP_SW):    state_d = S_MEMADR;
          (bus.opcode == OP_RTYPE): state_d = S_EXEC;
          (bus.opcode == OP_BEQ):   state_d = S_BRANCH;
`ifdef BNE_EN
          (bus.opcode == OP_BNE):   state_d = S_BRANCH;
`endif
          (bus.opcode == OP_ADDI):  state_d = S_ADDIEX;
          (bus.opcode == OP_J):     state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  ctrl_output_decode u_dec (
    .state_i  (state_q),
    .zero_i   (bus.zero),
    .is_bne_i (is_bne),
    .cw_o     (cw)
  );

  // While reset is held, FETCH shows but must not load PC or IR.
  assign bus.iord       = cw.iord;
  assign bus.mem_write  = cw.mem_write;
  assign bus.ir_write   = cw.ir_write & ~reset;
  assign bus.reg_dst    = cw.reg_dst;
  assign bus.mem_to_reg = cw.mem_to_reg;
  assign bus.reg_write  = cw.reg_write;
  assign bus.alu_src_a  = cw.alu_src_a;
  assign bus.alu_src_b  = cw.alu_src_b;
  assign bus.alu_op     = cw.alu_op;
  assign bus.pc_src     = cw.pc_src;
  assign bus.pc_en      = cw.pc_en & ~reset;
  assign bus.illegal_op = illegal_q;
  assign bus.dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: vector table,
// reset corner sequence and randomized instruction stream.
module tb_main_control_fsm;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RT    = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] BNEOP = 6'b000101;
  localparam logic [5:0] BAD   = 6'b111111;

`ifdef BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  typedef int q_t[$];

  typedef struct {
    logic [5:0] op;
    bit         z;
    int         lat;
    bit         ill;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_ill = 1'b0;

  always #5 clk = ~clk;

  main_control_fsm_if #(.STATE_W(4)) bus();

  main_control_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // State list an instruction walks through, FETCH first.
  function automatic q_t path(input logic [5:0] op);
    q_t q;
    if (op == LW)        q = {0, 1, 2, 3, 4};
    else if (op == SW)   q = {0, 1, 2, 5};
    else if (op == RT)   q = {0, 1, 6, 7};
    else if (op == ADDI) q = {0, 1, 9, 10};
    else if (op == BEQ)  q = {0, 1, 8};
    else if (op == JMP)  q = {0, 1, 11};
    else if (BNE && op == BNEOP) q = {0, 1, 8};
    else                 q = {0, 1};
    return q;
  endfunction

  function automatic logic [14:0] mk(
    input bit iord, input bit mw, input bit irw, input bit rd,
    input bit m2r, input bit rw, input bit asa,
    input logic [1:0] sb, input logic [2:0] aop,
    input logic [1:0] ps, input bit pe);
    return {iord, mw, irw, rd, m2r, rw, asa, sb, aop, ps, pe};
  endfunction

  // Expected control word for a state number.
  function automatic logic [14:0] exp_ctrl(input int st, input bit z,
                                           input bit bne);
    case (st)
      0: return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b01, 3'b000, 2'b00, 1'b1);
      1: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b11, 3'b000, 2'b00, 1'b0);
      2, 9: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      2'b10, 3'b000, 2'b00, 1'b0);
      3: return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b00, 3'b000, 2'b00, 1'b0);
      4: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                   2'b00, 3'b000, 2'b00, 1'b0);
      5: return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b00, 3'b000, 2'b00, 1'b0);
      6: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                   2'b00, 3'b010, 2'b00, 1'b0);
      7: return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                   2'b00, 3'b000, 2'b00, 1'b0);
      8: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                   2'b00, 3'b001, 2'b01, z ^ bne);
      10: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                    2'b00, 3'b000, 2'b00, 1'b0);
      11: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 3'b000, 2'b10, 1'b1);
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic [14:0] got_ctrl();
    return {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src, bus.pc_en};
  endfunction

  // Entered #1 after a negedge with the DUT in FETCH. Leaves at the
  // same point of the next FETCH; lat = cycles spent (0 on timeout).
  task automatic run_instr(input logic [5:0] op, input bit zfix,
                           input bit zval, output int lat);
    q_t q = path(op);
    bit bne = BNE && (op == BNEOP);
    bit z;
    int st;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      st = (n < q.size()) ? q[n] : 0;
      bus.opcode = (st == 1 || st == 2) ? op : 6'($urandom);
      z = (st == 8 && zfix) ? zval : 1'($urandom);
      bus.zero = z;
      #1;
      if (n > 0 && bus.dbg_state == 4'd0) begin
        lat = n;
        break;
      end
      chk("state", 32'(bus.dbg_state), 32'(st));
      chk("ctrl", 32'(got_ctrl()), 32'(exp_ctrl(st, z, bne)));
      chk("illegal_op", 32'(bus.illegal_op),
          32'((n == 0) ? exp_ill : 1'b0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[10];
    int   lat;
    bit   reached;
    logic [5:0] op;
    q_t   q;
    logic [5:0] ops[7];

    tab[0] = '{LW,    1'b0, 5, 1'b0};
    tab[1] = '{SW,    1'b0, 4, 1'b0};
    tab[2] = '{RT,    1'b0, 4, 1'b0};
    tab[3] = '{ADDI,  1'b1, 4, 1'b0};
    tab[4] = '{BEQ,   1'b1, 3, 1'b0};
    tab[5] = '{BEQ,   1'b0, 3, 1'b0};
    tab[6] = '{JMP,   1'b0, 3, 1'b0};
    tab[7] = '{BAD,   1'b0, 2, 1'b1};
    tab[8] = '{BNEOP, 1'b0, BNE ? 3 : 2, !BNE};
    tab[9] = '{LW,    1'b1, 5, 1'b0};
    ops = '{LW, SW, RT, ADDI, BEQ, JMP, BNEOP};

    reset = 1'b1;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    #1;
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    chk("rst_ctrl", 32'(got_ctrl()),
        32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               2'b01, 3'b000, 2'b00, 1'b0)));
    chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("deassert_pc_en", 32'(bus.pc_en), 32'd1);
    chk("deassert_ir_write", 32'(bus.ir_write), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_instr(tab[i].op, 1'b1, tab[i].z, lat);
      chk("tab_latency", 32'(lat), 32'(tab[i].lat));
      chk("tab_illegal", 32'(bus.illegal_op), 32'(tab[i].ill));
      exp_ill = tab[i].ill;
    end

    reached = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.opcode = SW;
      #1;
      if (bus.dbg_state == 4'd5) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reach_memwr", 32'(reached), 32'd1);
    chk("memwr_mem_write", 32'(bus.mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("arst_state", 32'(bus.dbg_state), 32'd0);
    chk("arst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("arst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("arst_illegal", 32'(bus.illegal_op), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rel_ir_write", 32'(bus.ir_write), 32'd1);
    @(posedge clk);
    #1;
    chk("rel_first_edge", 32'(bus.dbg_state), 32'd1);

    reached = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.opcode = JMP;
      #1;
      if (bus.dbg_state == 4'd0) begin
        reached = 1'b1;
        break;
      end
    end
    chk("resync_fetch", 32'(reached), 32'd1);
    exp_ill = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      q = path(op);
      run_instr(op, 1'b0, 1'b0, lat);
      chk("rand_latency", 32'(lat), 32'(q.size()));
      exp_ill = (q.size() == 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
